// File: rtl/rvfi_seq_pkg.sv
// Shared definitions for the RVFI check sequencer.
//   seq_state_e          : sequencer FSM states
//   DEFAULT_TIMEOUT      : default retirement stall limit (cycles)
//   DEFAULT_RESET_CYCLES : default core/checker reset hold window (cycles)
//   *_MASK / *_MATCH     : opcode patterns for common RV32I instructions
//   insn_matches()       : (insn & mask) == match
package rvfi_seq_pkg;

  typedef enum logic [1:0] {
    SEQ_HOLD  = 2'd0,
    SEQ_RUN   = 2'd1,
    SEQ_DONE  = 2'd2,
    SEQ_STALL = 2'd3
  } seq_state_e;

  localparam int unsigned DEFAULT_TIMEOUT      = 64;
  localparam int unsigned DEFAULT_RESET_CYCLES = 4;

  // R-type: funct7, funct3 and opcode are significant
  localparam logic [31:0] ADD_MASK  = 32'hFE00_707F;
  localparam logic [31:0] ADD_MATCH = 32'h0000_0033;
  // I/S/B-type: funct3 and opcode are significant
  localparam logic [31:0] LW_MASK   = 32'h0000_707F;
  localparam logic [31:0] LW_MATCH  = 32'h0000_2003;
  localparam logic [31:0] SW_MASK   = 32'h0000_707F;
  localparam logic [31:0] SW_MATCH  = 32'h0000_2023;
  localparam logic [31:0] BEQ_MASK  = 32'h0000_707F;
  localparam logic [31:0] BEQ_MATCH = 32'h0000_0063;
  // J-type: opcode only
  localparam logic [31:0] JAL_MASK  = 32'h0000_007F;
  localparam logic [31:0] JAL_MATCH = 32'h0000_006F;

  function automatic logic insn_matches(input logic [31:0] insn,
                                        input logic [31:0] mask,
                                        input logic [31:0] match);
    return (insn & mask) == match;
  endfunction

endpackage

// File: rtl/rvfi_order_monitor.sv
// Tracks rvfi_order continuity across retirements.
//   clock, reset     : clock, synchronous active-low reset
//   enable           : tracking active (sequencer in RUN or DONE)
//   rvfi_valid       : retirement strobe
//   rvfi_order       : retirement index
//   order_err        : sticky, set when an order is not previous+1
module rvfi_order_monitor (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        rvfi_valid,
  input  logic [63:0] rvfi_order,
  output logic        order_err
);

  logic [63:0] last_order;
  logic        last_valid;

  always_ff @(posedge clock) begin
    if (!reset) begin
      last_order <= '0;
      last_valid <= 1'b0;
      order_err  <= 1'b0;
    end else if (enable && rvfi_valid) begin
      // First retirement only seeds the reference value
      if (last_valid && (rvfi_order != last_order + 64'd1)) begin
        order_err <= 1'b1;
      end
      last_order <= rvfi_order;
      last_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/rvfi_check_sequencer.sv
// Sequences the single-instruction RVFI check of the formal harness.
// Holds core/checker in reset for RESET_CYCLES, then counts retirements
// matching cfg_mask/cfg_match and strobes check on the (cfg_skip+1)th one.
//   clock, reset          : clock, synchronous active-low reset
//   rvfi_valid/insn/order : retirement stream
//   cfg_match, cfg_mask   : opcode pattern (mask 0 matches everything)
//   cfg_skip              : matching retirements to pass before the check
//   chk_reset             : active-high reset to core and checker
//   check                 : combinational one-cycle check strobe
//   done                  : check has been issued
//   order_err, timeout    : sticky trace-health flags
//   match_cnt             : matching retirements seen so far (saturating)
module rvfi_check_sequencer
  import rvfi_seq_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned RESET_CYCLES = DEFAULT_RESET_CYCLES,
  parameter int unsigned SKIP_W       = 8,
  parameter int unsigned TIMEOUT      = DEFAULT_TIMEOUT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rvfi_valid,
  input  logic [31:0]       rvfi_insn,
  input  logic [63:0]       rvfi_order,
  input  logic [31:0]       cfg_match,
  input  logic [31:0]       cfg_mask,
  input  logic [SKIP_W-1:0] cfg_skip,
  output logic              chk_reset,
  output logic              check,
  output logic              done,
  output logic              order_err,
  output logic              timeout,
  output logic [SKIP_W-1:0] match_cnt
);

  localparam int unsigned HOLD_W  = $clog2(RESET_CYCLES + 1);
  localparam int unsigned STALL_W = $clog2(TIMEOUT + 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT - 1);

  if (XLEN < 32 || RESET_CYCLES < 1 || TIMEOUT < 1) begin : g_bad_param
    $error("rvfi_check_sequencer: XLEN>=32, RESET_CYCLES>=1, TIMEOUT>=1 required");
  end

  seq_state_e         state_q, state_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic [SKIP_W-1:0]  match_q, match_d;
  logic               timeout_q, timeout_d;
  logic               insn_hit;

  assign insn_hit = insn_matches(rvfi_insn, cfg_mask, cfg_match);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= SEQ_HOLD;
      hold_q    <= '0;
      stall_q   <= '0;
      match_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      stall_q   <= stall_d;
      match_q   <= match_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    stall_d   = stall_q;
    match_d   = match_q;
    timeout_d = timeout_q;
    check     = 1'b0;
    case (state_q)
      SEQ_HOLD: begin
        hold_d = hold_q + HOLD_W'(1);
        if (hold_q == HOLD_LAST) begin
          state_d = SEQ_RUN;
        end
      end
      SEQ_RUN: begin
        if (rvfi_valid) begin
          // A retirement always wins over the stall limit in the same cycle
          stall_d = '0;
          if (insn_hit) begin
            if (match_q == cfg_skip) begin
              check   = 1'b1;
              state_d = SEQ_DONE;
            end else if (match_q != '1) begin
              match_d = match_q + SKIP_W'(1);
            end
          end
        end else begin
          stall_d = stall_q + STALL_W'(1);
          if (stall_q == STALL_LAST) begin
            timeout_d = 1'b1;
            state_d   = SEQ_STALL;
          end
        end
      end
      default: ;
    endcase
  end

  assign chk_reset = (state_q == SEQ_HOLD);
  assign done      = (state_q == SEQ_DONE);
  assign timeout   = timeout_q;
  assign match_cnt = match_q;

  rvfi_order_monitor u_order_monitor (
    .clock      (clock),
    .reset      (reset),
    .enable     ((state_q == SEQ_RUN) || (state_q == SEQ_DONE)),
    .rvfi_valid (rvfi_valid),
    .rvfi_order (rvfi_order),
    .order_err  (order_err)
  );

endmodule

// File: tb/tb_rvfi_check_sequencer.sv
// Directed bench for rvfi_check_sequencer (RESET_CYCLES=4, TIMEOUT=8).
// Cycle 0 is the first cycle with reset=1; the sequencer runs from cycle 4.
module tb_rvfi_check_sequencer;
  import rvfi_seq_pkg::*;

  localparam logic [31:0] I_ADD = 32'h00B5_0533; // add a0,a0,a1
  localparam logic [31:0] I_LW  = 32'h0005_A503; // lw  a0,0(a1)

  logic        clock;
  logic        reset;
  logic        rvfi_valid;
  logic [31:0] rvfi_insn;
  logic [63:0] rvfi_order;
  logic [31:0] cfg_match;
  logic [31:0] cfg_mask;
  logic [7:0]  cfg_skip;
  logic        chk_reset;
  logic        check;
  logic        done;
  logic        order_err;
  logic        timeout;
  logic [7:0]  match_cnt;

  int unsigned n_tests;
  int unsigned n_fail;

  rvfi_check_sequencer #(
    .XLEN         (32),
    .RESET_CYCLES (4),
    .SKIP_W       (8),
    .TIMEOUT      (8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .rvfi_valid (rvfi_valid),
    .rvfi_insn  (rvfi_insn),
    .rvfi_order (rvfi_order),
    .cfg_match  (cfg_match),
    .cfg_mask   (cfg_mask),
    .cfg_skip   (cfg_skip),
    .chk_reset  (chk_reset),
    .check      (check),
    .done       (done),
    .order_err  (order_err),
    .timeout    (timeout),
    .match_cnt  (match_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic        valid;
    logic [31:0] insn;
    logic [63:0] order;
    logic        e_chk_reset;
    logic        e_check;
    logic        e_done;
    logic        e_order_err;
    logic        e_timeout;
    logic [7:0]  e_match_cnt;
  } vec_t;

  vec_t tv[12];

  task automatic cmp(input string tag, input string name,
                     input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s %s: got %0h expected %0h", tag, name, act, exp);
    end
  endtask

  // Drive one cycle, compare mid-cycle, then advance past the next edge
  task automatic step(input vec_t v, input string tag);
    reset      = v.rst;
    rvfi_valid = v.valid;
    rvfi_insn  = v.insn;
    rvfi_order = v.order;
    #2;
    cmp(tag, "chk_reset", 64'(chk_reset), 64'(v.e_chk_reset));
    cmp(tag, "check",     64'(check),     64'(v.e_check));
    cmp(tag, "done",      64'(done),      64'(v.e_done));
    cmp(tag, "order_err", 64'(order_err), 64'(v.e_order_err));
    cmp(tag, "timeout",   64'(timeout),   64'(v.e_timeout));
    cmp(tag, "match_cnt", 64'(match_cnt), 64'(v.e_match_cnt));
    @(posedge clock);
    #1;
  endtask

  function automatic vec_t mk(input logic rst, input logic valid,
                              input logic [31:0] insn, input logic [63:0] order,
                              input logic cr, input logic ck, input logic dn,
                              input logic oe, input logic to, input logic [7:0] mc);
    vec_t v;
    v = '{rst, valid, insn, order, cr, ck, dn, oe, to, mc};
    return v;
  endfunction

  // One reset edge with idle inputs; returns just after that edge
  task automatic apply_reset();
    reset      = 1'b0;
    rvfi_valid = 1'b0;
    rvfi_insn  = '0;
    rvfi_order = '0;
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    cfg_mask  = ADD_MASK;
    cfg_match = ADD_MATCH;
    cfg_skip  = 8'd2;

    // skip=2: valid during HOLD ignored, ADD/LW/ADD/ADD stream checks third
    // ADD, orders 0,1,2,4 break continuity on the fourth retirement
    //            rst v  insn   order  cr ck dn oe to mc
    tv[0]  = mk(1'b0, 1, I_ADD, 64'd0, 1, 0, 0, 0, 0, 8'd0); // in reset
    tv[1]  = mk(1'b1, 1, I_ADD, 64'd5, 1, 0, 0, 0, 0, 8'd0); // c0 HOLD
    tv[2]  = mk(1'b1, 1, I_ADD, 64'd7, 1, 0, 0, 0, 0, 8'd0); // c1
    tv[3]  = mk(1'b1, 0, I_ADD, 64'd0, 1, 0, 0, 0, 0, 8'd0); // c2
    tv[4]  = mk(1'b1, 1, I_ADD, 64'd9, 1, 0, 0, 0, 0, 8'd0); // c3
    tv[5]  = mk(1'b1, 1, I_ADD, 64'd0, 0, 0, 0, 0, 0, 8'd0); // c4 RUN
    tv[6]  = mk(1'b1, 1, I_LW,  64'd1, 0, 0, 0, 0, 0, 8'd1); // c5
    tv[7]  = mk(1'b1, 0, I_ADD, 64'd0, 0, 0, 0, 0, 0, 8'd1); // c6 stall
    tv[8]  = mk(1'b1, 1, I_ADD, 64'd2, 0, 0, 0, 0, 0, 8'd1); // c7
    tv[9]  = mk(1'b1, 1, I_ADD, 64'd4, 0, 1, 0, 0, 0, 8'd2); // c8 check
    tv[10] = mk(1'b1, 1, I_ADD, 64'd5, 0, 0, 1, 1, 0, 8'd2); // c9 DONE
    tv[11] = mk(1'b1, 0, I_ADD, 64'd0, 0, 0, 1, 1, 0, 8'd2); // c10

    apply_reset();
    for (int i = 0; i < 12; i++) begin
      step(tv[i], $sformatf("tbl[%0d]", i));
    end

    // Stall: no retirement after RUN entry, timeout on the 8th stall cycle
    cfg_skip = 8'd0;
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      step(mk(1, 0, I_ADD, 0, 1, 0, 0, 0, 0, 8'd0), $sformatf("stall_hold%0d", c));
    end
    for (int c = 4; c < 12; c++) begin
      step(mk(1, 0, I_ADD, 0, 0, 0, 0, 0, 0, 8'd0), $sformatf("stall_c%0d", c));
    end
    step(mk(1, 1, I_ADD, 64'd0, 0, 0, 0, 0, 1, 8'd0), "stall_c12");
    step(mk(1, 1, I_ADD, 64'd1, 0, 0, 0, 0, 1, 8'd0), "stall_c13");

    // skip=0: ADD in first RUN cycle checks immediately; reset clears timeout
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      step(mk(1, 0, I_ADD, 0, 1, 0, 0, 0, 0, 8'd0), $sformatf("first_hold%0d", c));
    end
    step(mk(1, 1, I_ADD, 64'd100, 0, 1, 0, 0, 0, 8'd0), "first_c4");
    step(mk(1, 1, I_ADD, 64'd101, 0, 0, 1, 0, 0, 8'd0), "first_c5");
    step(mk(1, 1, I_ADD, 64'd105, 0, 0, 1, 0, 0, 8'd0), "first_c6");
    step(mk(1, 0, I_ADD, 64'd0,   0, 0, 1, 1, 0, 8'd0), "first_c7");

    // Reset pulse after DONE: flags clear, 4-cycle hold, checks again
    step(mk(0, 0, I_ADD, 0, 0, 0, 1, 1, 0, 8'd0), "rerun_rst");
    for (int c = 0; c < 4; c++) begin
      step(mk(1, 0, I_ADD, 0, 1, 0, 0, 0, 0, 8'd0), $sformatf("rerun_hold%0d", c));
    end
    step(mk(1, 1, I_ADD, 64'd7, 0, 1, 0, 0, 0, 8'd0), "rerun_c4");
    step(mk(1, 1, I_ADD, 64'd8, 0, 0, 1, 0, 0, 8'd0), "rerun_c5");

    // Mask 0 matches any instruction; skip=1 checks the second retirement
    cfg_mask  = '0;
    cfg_match = '0;
    cfg_skip  = 8'd1;
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      step(mk(1, 0, I_LW, 0, 1, 0, 0, 0, 0, 8'd0), $sformatf("any_hold%0d", c));
    end
    step(mk(1, 1, I_LW,  64'd0, 0, 0, 0, 0, 0, 8'd0), "any_c4");
    step(mk(1, 1, I_ADD, 64'd1, 0, 1, 0, 0, 0, 8'd1), "any_c5");
    step(mk(1, 0, I_ADD, 64'd0, 0, 0, 1, 0, 0, 8'd1), "any_c6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
